multicycle_control: RTL and testbench

Multi-cycle sequencer for the single-issue MIPS-subset datapath. It replaces the single-cycle decode-only controller and walks each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath mux and enable, and stalls on a ready handshake with the shared instruction/data memory. It sits between the instruction register (op/func inputs) and the datapath.

---
 rtl/mcu_pkg.sv | 53 +++++
 rtl/alu_decoder.sv | 24 ++
 rtl/multicycle_control.sv | 148 ++++++++++++++
 tb/tb_multicycle_control.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared constants for the multi-cycle controller: opcodes, funct codes, ALU codes,
// mux selects and the 4-bit state encoding.
package mcu_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OP_W-1:0] OP_J     = 6'd2;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OP_W-1:0] OP_LW    = 6'd35;
    localparam logic [OP_W-1:0] OP_SW    = 6'd43;

    localparam logic [OP_W-1:0] FN_ADD = 6'd32;
    localparam logic [OP_W-1:0] FN_SUB = 6'd34;
    localparam logic [OP_W-1:0] FN_AND = 6'd36;
    localparam logic [OP_W-1:0] FN_OR  = 6'd37;
    localparam logic [OP_W-1:0] FN_NOR = 6'd39;
    localparam logic [OP_W-1:0] FN_SLT = 6'd42;

    localparam logic [ALUC_W-1:0] ALUC_ADD = 3'b010;
    localparam logic [ALUC_W-1:0] ALUC_SUB = 3'b110;
    localparam logic [ALUC_W-1:0] ALUC_AND = 3'b000;
    localparam logic [ALUC_W-1:0] ALUC_OR  = 3'b001;
    localparam logic [ALUC_W-1:0] ALUC_NOR = 3'b100;
    localparam logic [ALUC_W-1:0] ALUC_SLT = 3'b111;

    localparam logic [1:0] ALUB_RT   = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;
    localparam logic [1:0] ALUB_IMM4 = 2'b11;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_OUT  = 2'b01;
    localparam logic [1:0] PCS_JUMP = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_MEM = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_HALT   = 4'd15
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct decoder: maps func to an ALU operation and flags unsupported codes.
module alu_decoder
    import mcu_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] aluc_c,
    output logic       legal_c
);

    always_comb begin
        aluc_c  = ALUC_ADD;
        legal_c = 1'b1;
        case (func)
            FN_ADD:  aluc_c = ALUC_ADD;
            FN_SUB:  aluc_c = ALUC_SUB;
            FN_AND:  aluc_c = ALUC_AND;
            FN_OR:   aluc_c = ALUC_OR;
            FN_NOR:  aluc_c = ALUC_NOR;
            FN_SLT:  aluc_c = ALUC_SLT;
            default: legal_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset sequencer with a ready handshake to shared memory.
// Define MCU_JUMP_EN to decode op 2 (j) into the JUMP state; otherwise op 2 halts.
module multicycle_control
    import mcu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       MemRead,
    output logic       writeMem,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUC,
    output logic       WriteReg,
    output logic       MemToReg,
    output logic       Regrt,
    output logic       Halted,
    output logic [3:0] state
);

    state_t     cur, nxt;
    logic [2:0] dec_aluc;
    logic       dec_legal;

    alu_decoder u_alu_decoder (
        .func    (func),
        .aluc_c  (dec_aluc),
        .legal_c (dec_legal)
    );

    // State register; async reset drops every decoded output at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= S_IDLE;
        else      cur <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:   nxt = S_FETCH;
            S_FETCH:  if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     nxt = dec_legal ? S_EXEC_R : S_HALT;
                    OP_LW, OP_SW: nxt = S_ADDR;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J: begin
`ifdef MCU_JUMP_EN
                        nxt = S_JUMP;
`else
                        nxt = S_HALT;
`endif
                    end
                    default:      nxt = S_HALT;
                endcase
            end
            S_EXEC_R: nxt = S_WB_R;
            S_WB_R:   nxt = S_FETCH;
            S_ADDR: begin
                if (op == OP_LW)      nxt = S_MEM_RD;
                else if (op == OP_SW) nxt = S_MEM_WR;
                else                  nxt = S_HALT;
            end
            S_MEM_RD: if (mem_ready) nxt = S_WB_MEM;
            S_WB_MEM: nxt = S_FETCH;
            S_MEM_WR: if (mem_ready) nxt = S_FETCH;
            S_BRANCH: nxt = S_FETCH;
            S_JUMP:   nxt = S_FETCH;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_HALT;
        endcase
    end

    // Moore output decode; FETCH and BRANCH PCWrite/IRWrite follow mem_ready/zero.
    always_comb begin
        MemRead  = 1'b0;
        writeMem = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = PCS_ALU;
        ALUSrcA  = 1'b0;
        ALUSrcB  = ALUB_RT;
        ALUC     = ALUC_AND;
        WriteReg = 1'b0;
        MemToReg = 1'b0;
        Regrt    = 1'b0;
        Halted   = 1'b0;
        state    = 4'(cur);
        case (cur)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = ALUB_FOUR;
                ALUC    = ALUC_ADD;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = ALUB_IMM4;
                ALUC    = ALUC_ADD;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUC    = dec_aluc;
            end
            S_WB_R:   WriteReg = 1'b1;
            S_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUB_IMM;
                ALUC    = ALUC_ADD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_WB_MEM: begin
                WriteReg = 1'b1;
                MemToReg = 1'b1;
                Regrt    = 1'b1;
            end
            S_MEM_WR: begin
                writeMem = 1'b1;
                IorD     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUC    = ALUC_SUB;
                PCSrc   = PCS_OUT;
                PCWrite = zero;
            end
            S_JUMP: begin
                PCSrc   = PCS_JUMP;
                PCWrite = 1'b1;
            end
            S_HALT:   Halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, func;
    logic       zero, mem_ready;
    logic       MemRead, writeMem, IorD, IRWrite, PCWrite, ALUSrcA;
    logic [1:0] PCSrc, ALUSrcB;
    logic [2:0] ALUC;
    logic       WriteReg, MemToReg, Regrt, Halted;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    multicycle_control dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .MemRead(MemRead), .writeMem(writeMem), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUC(ALUC), .WriteReg(WriteReg), .MemToReg(MemToReg), .Regrt(Regrt),
        .Halted(Halted), .state(state)
    );

    always #5 clk = ~clk;

    // All outputs except state, MSB first: MemRead..Halted (17 bits)
    wire [16:0] outs = {MemRead, writeMem, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA,
                        ALUSrcB, ALUC, WriteReg, MemToReg, Regrt, Halted};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [2:0] exp_aluc [5];
    logic [5:0] fn_list [5];

    initial begin
        fn_list  = '{6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
        exp_aluc = '{3'b110, 3'b000, 3'b001, 3'b100, 3'b111};

        rst = 1'b0; op = 6'd0; func = 6'd32; zero = 1'b0; mem_ready = 1'b1;
        step(); step();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_outs", 32'(outs), 32'd0);

        // add with zero-wait memory: 0,1,2,3,4,1
        rst = 1'b1; #1;
        chk("idle_after_release", 32'(state), 32'd0);
        step();
        chk("add_fetch_state", 32'(state), 32'd1);
        chk("add_fetch_outs", 32'(outs), 32'b1_0_0_1_1_00_0_01_010_0_0_0_0);
        step();
        chk("add_decode_state", 32'(state), 32'd2);
        chk("add_decode_outs", 32'(outs), 32'b0_0_0_0_0_00_0_11_010_0_0_0_0);
        step();
        chk("add_exec_state", 32'(state), 32'd3);
        chk("add_exec_outs", 32'(outs), 32'b0_0_0_0_0_00_1_00_010_0_0_0_0);
        step();
        chk("add_wb_state", 32'(state), 32'd4);
        chk("add_wb_outs", 32'(outs), 32'b0_0_0_0_0_00_0_00_000_1_0_0_0);
        step();
        chk("add_back_fetch", 32'(state), 32'd1);

        // lw with two wait cycles in MEM_RD
        op = 6'd35;
        step();
        chk("lw_decode", 32'(state), 32'd2);
        step();
        chk("lw_addr_state", 32'(state), 32'd5);
        chk("lw_addr_outs", 32'(outs), 32'b0_0_0_0_0_00_1_10_010_0_0_0_0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_ready = 1'b1;
            if (i > 0) #1;
            if (i == 0) step(); else if (i == 1) step(); else #0;
            chk($sformatf("lw_memrd_state_%0d", i), 32'(state), 32'd6);
            chk($sformatf("lw_memrd_outs_%0d", i), 32'(outs), 32'b1_0_1_0_0_00_0_00_000_0_0_0_0);
        end
        step();
        chk("lw_wbmem_state", 32'(state), 32'd7);
        chk("lw_wbmem_outs", 32'(outs), 32'b0_0_0_0_0_00_0_00_000_1_1_1_0);
        step();
        chk("lw_back_fetch", 32'(state), 32'd1);

        // beq taken, then not-taken in the same BRANCH cycle
        op = 6'd4; zero = 1'b1;
        step(); step();
        chk("beq_state", 32'(state), 32'd9);
        chk("beq_taken_outs", 32'(outs), 32'b0_0_0_0_1_01_1_00_110_0_0_0_0);
        zero = 1'b0; #1;
        chk("beq_not_taken_pcwrite", 32'(PCWrite), 32'd0);
        step();
        chk("beq_back_fetch", 32'(state), 32'd1);

        // funct sweep
        op = 6'd0;
        for (int i = 0; i < 5; i++) begin
            func = fn_list[i];
            step(); step();
            chk($sformatf("fn%0d_state", fn_list[i]), 32'(state), 32'd3);
            chk($sformatf("fn%0d_aluc", fn_list[i]), 32'(ALUC), 32'(exp_aluc[i]));
            step(); step();
        end
        chk("sweep_back_fetch", 32'(state), 32'd1);

        // sw, reset while writing
        op = 6'd43;
        step(); step();
        chk("sw_addr", 32'(state), 32'd5);
        mem_ready = 1'b0;
        step();
        chk("sw_memwr_state", 32'(state), 32'd8);
        chk("sw_memwr_outs", 32'(outs), 32'b0_1_1_0_0_00_0_00_000_0_0_0_0);
        rst = 1'b0; #1;
        chk("sw_abort_writemem", 32'(writeMem), 32'd0);
        chk("sw_abort_state", 32'(state), 32'd0);
        mem_ready = 1'b1;
        step();
        rst = 1'b1; #1;
        chk("sw_release_idle", 32'(state), 32'd0);
        step();
        chk("sw_first_fetch", 32'(state), 32'd1);

        // illegal funct halts until reset
        op = 6'd0; func = 6'd33;
        step(); step();
        chk("ill_state", 32'(state), 32'd15);
        chk("ill_outs", 32'(outs), 32'd1);
        step(); step(); step();
        chk("ill_sticky_state", 32'(state), 32'd15);
        chk("ill_sticky_halted", 32'(Halted), 32'd1);
        rst = 1'b0; #1;
        chk("ill_reset_halted", 32'(Halted), 32'd0);
        rst = 1'b1;
        step();
        chk("ill_refetch", 32'(state), 32'd1);

        // jump
        op = 6'd2;
        step(); step();
`ifdef MCU_JUMP_EN
        chk("j_state", 32'(state), 32'd10);
        chk("j_outs", 32'(outs), 32'b0_0_0_0_1_10_0_00_000_0_0_0_0);
        step();
        chk("j_back_fetch", 32'(state), 32'd1);
`else
        chk("j_state", 32'(state), 32'd15);
        chk("j_outs", 32'(outs), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
